// File: rtl/axis_crc_stream_engine_if.sv
//------------------------------------------------------------------------------
// axis_crc_stream_engine_if : AXI-Stream input/output bundle of the CRC engine
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface axis_crc_stream_engine_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CRC_WIDTH  = 32
);
   logic [DATA_WIDTH-1:0]   s_axis_tdata;
   logic [DATA_WIDTH/8-1:0] s_axis_tkeep;
   logic                    s_axis_tlast;
   logic                    s_axis_tvalid;
   logic                    s_axis_tready;
   logic [CRC_WIDTH-1:0]    m_axis_tdata;
   logic                    m_axis_tvalid;
   logic                    m_axis_tready;
   logic                    crc_done;

   // Engine side: consumes the input stream, produces the CRC stream
   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, crc_done
   );

   // Environment side: drives packets in, accepts CRC words out
   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, crc_done
   );
endinterface

`default_nettype wire

// File: rtl/axis_crc_stream_engine.sv
//------------------------------------------------------------------------------
// axis_crc_stream_engine : packet CRC over AXI-Stream beats, one CRC word per packet
// Optional AXIS_CRC_CHECK_EN adds crc_ok (packet with appended CRC checks clean)
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axis_crc_stream_engine #(
   parameter int          DATA_WIDTH = 32,
   parameter int          CRC_WIDTH  = 32,
   parameter logic [31:0] POLY_CRC   = 32'h04C11DB7,
   parameter logic [31:0] INIT_CRC   = 32'hFFFFFFFF,
   parameter logic [31:0] XOR_OUT    = 32'h00000000
) (
   input  wire                        aclk,
   input  wire                        aresetn,
   axis_crc_stream_engine_if.slave    axis
`ifdef AXIS_CRC_CHECK_EN
   ,
   output logic                       crc_ok
`endif
);

   localparam int                   c_num_lanes = DATA_WIDTH / 8;
   localparam logic [CRC_WIDTH-1:0] c_poly      = POLY_CRC[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] c_init      = INIT_CRC[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] c_xor       = XOR_OUT[CRC_WIDTH-1:0];

   typedef enum logic [0:0] {
      ST_ACCUM  = 1'b0,
      ST_OUTPUT = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [CRC_WIDTH-1:0]   crc_q, crc_d;
   logic                   s_ready_q, s_ready_d;
   logic                   m_valid_q, m_valid_d;
   logic [CRC_WIDTH-1:0]   m_data_q, m_data_d;
   logic                   done_q, done_d;
`ifdef AXIS_CRC_CHECK_EN
   logic                   crc_ok_q, crc_ok_d;
`endif

   logic [CRC_WIDTH-1:0]   w_crc_calc;
   logic                   w_fb;
   logic                   w_s_hs;
   logic                   w_m_hs;

   assign w_s_hs = s_ready_q & axis.s_axis_tvalid;
   assign w_m_hs = m_valid_q & axis.m_axis_tready;

   // Bitwise serial CRC unrolled over the whole beat; on the last beat, lanes
   // with tkeep clear are skipped so set lanes are consumed in ascending order.
   always_comb begin
      w_crc_calc = crc_q;
      w_fb       = 1'b0;
      for (int i = 0; i < c_num_lanes; i++) begin
         if (!axis.s_axis_tlast || axis.s_axis_tkeep[i]) begin
            for (int b = 7; b >= 0; b--) begin
               w_fb       = w_crc_calc[CRC_WIDTH-1] ^ axis.s_axis_tdata[8*i+b];
               w_crc_calc = {w_crc_calc[CRC_WIDTH-2:0], 1'b0} ^ (w_fb ? c_poly : '0);
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      s_ready_d = s_ready_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      done_d    = 1'b0;
`ifdef AXIS_CRC_CHECK_EN
      crc_ok_d  = crc_ok_q;
`endif
      case (state_q)
         ST_ACCUM: begin
            s_ready_d = 1'b1;
            if (w_s_hs) begin
               crc_d = w_crc_calc;
               if (axis.s_axis_tlast) begin
                  state_d   = ST_OUTPUT;
                  crc_d     = c_init;
                  m_data_d  = w_crc_calc ^ c_xor;
                  m_valid_d = 1'b1;
                  done_d    = 1'b1;
                  s_ready_d = 1'b0;
`ifdef AXIS_CRC_CHECK_EN
                  crc_ok_d  = ((w_crc_calc ^ c_xor) == '0);
`endif
               end
            end
         end
         ST_OUTPUT: begin
            if (w_m_hs) begin
               state_d   = ST_ACCUM;
               m_valid_d = 1'b0;
               m_data_d  = '0;
               s_ready_d = 1'b1;
`ifdef AXIS_CRC_CHECK_EN
               crc_ok_d  = 1'b0;
`endif
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= ST_ACCUM;
         crc_q     <= c_init;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         done_q    <= 1'b0;
`ifdef AXIS_CRC_CHECK_EN
         crc_ok_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         done_q    <= done_d;
`ifdef AXIS_CRC_CHECK_EN
         crc_ok_q  <= crc_ok_d;
`endif
      end
   end

   assign axis.s_axis_tready = s_ready_q;
   assign axis.m_axis_tvalid = m_valid_q;
   assign axis.m_axis_tdata  = m_data_q;
   assign axis.crc_done      = done_q;
`ifdef AXIS_CRC_CHECK_EN
   assign crc_ok             = crc_ok_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_crc_stream_engine.sv
//------------------------------------------------------------------------------
// tb_axis_crc_stream_engine : directed self-checking bench for the CRC engine
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_crc_stream_engine;

   logic aclk;
   logic aresetn;
   int   checks;
   int   errors;

   axis_crc_stream_engine_if #(.DATA_WIDTH(32), .CRC_WIDTH(32)) bus ();

`ifdef AXIS_CRC_CHECK_EN
   logic crc_ok;
`endif

   axis_crc_stream_engine #(
      .DATA_WIDTH (32),
      .CRC_WIDTH  (32),
      .POLY_CRC   (32'h04C11DB7),
      .INIT_CRC   (32'hFFFFFFFF),
      .XOR_OUT    (32'h00000000)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .axis    (bus.slave)
`ifdef AXIS_CRC_CHECK_EN
      ,
      .crc_ok  (crc_ok)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Drive one beat and hold it until the engine accepts it
   task automatic send_beat(input logic [31:0] data, input logic [3:0] keep, input logic last);
      int n;
      bus.s_axis_tdata  = data;
      bus.s_axis_tkeep  = keep;
      bus.s_axis_tlast  = last;
      bus.s_axis_tvalid = 1'b1;
      n = 0;
      while (!bus.s_axis_tready && n < 100) begin
         @(posedge aclk); #1;
         n++;
      end
      if (!bus.s_axis_tready) begin
         checks++;
         errors++;
         $display("FAIL send_beat_timeout: s_axis_tready=%0b required=1", bus.s_axis_tready);
      end
      @(posedge aclk); #1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
   endtask

   task automatic send_123456789();
      send_beat(32'h34333231, 4'hF, 1'b0);
      send_beat(32'h38373635, 4'hF, 1'b0);
      send_beat(32'h00000039, 4'b0001, 1'b1);
   endtask

   // Called right after the tlast beat is accepted: output must already be up
   task automatic check_result(input string name, input logic [31:0] exp);
      checks++;
      if (bus.m_axis_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL %s_tvalid: got=%0b required=1", name, bus.m_axis_tvalid);
      end
      checks++;
      if (bus.m_axis_tdata !== exp) begin
         errors++;
         $display("FAIL %s_tdata: got=%08h required=%08h", name, bus.m_axis_tdata, exp);
      end
      checks++;
      if (bus.crc_done !== 1'b1) begin
         errors++;
         $display("FAIL %s_crc_done: got=%0b required=1", name, bus.crc_done);
      end
   endtask

   task automatic accept_result(input string name);
      bus.m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      bus.m_axis_tready = 1'b0;
      checks++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== 32'h0) begin
         errors++;
         $display("FAIL %s_accept: tvalid=%0b tdata=%08h required tvalid=0 tdata=0",
                  name, bus.m_axis_tvalid, bus.m_axis_tdata);
      end
      checks++;
      if (bus.s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready_after_accept: got=%0b required=1", name, bus.s_axis_tready);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      checks++;
      if (bus.s_axis_tready !== 1'b0 || bus.m_axis_tvalid !== 1'b0 ||
          bus.m_axis_tdata !== 32'h0 || bus.crc_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: s_tready=%0b m_tvalid=%0b m_tdata=%08h done=%0b required 0/0/0/0",
                  bus.s_axis_tready, bus.m_axis_tvalid, bus.m_axis_tdata, bus.crc_done);
      end
      aresetn = 1'b1;
      @(posedge aclk); #1;
      checks++;
      if (bus.s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got=%0b required=1", bus.s_axis_tready);
      end
   endtask

   task automatic test_basic();
      send_123456789();
      check_result("basic", 32'h0376E6E7);
      @(posedge aclk); #1;
      checks++;
      if (bus.crc_done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse: got=%0b required=0", bus.crc_done);
      end
      accept_result("basic");
   endtask

   task automatic test_empty();
      send_beat(32'hDEADBEEF, 4'b0000, 1'b1);
      check_result("empty", 32'hFFFFFFFF);
      accept_result("empty");
   endtask

   task automatic test_back_to_back();
      int bad;
      send_123456789();
      check_result("bp1", 32'h0376E6E7);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk); #1;
         if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 32'h0376E6E7 ||
             bus.s_axis_tready !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL backpressure_hold: bad_cycles=%0d required=0", bad);
      end
      accept_result("bp1");
      send_123456789();
      check_result("bp2", 32'h0376E6E7);
      accept_result("bp2");
   endtask

   task automatic test_gaps();
      logic [31:0] d [3];
      logic [3:0]  k [3];
      d[0] = 32'h34333231; d[1] = 32'h38373635; d[2] = 32'h00000039;
      k[0] = 4'hF;         k[1] = 4'hF;         k[2] = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(1, 4)) @(posedge aclk);
         #1;
         send_beat(d[i], k[i], (i == 2));
      end
      check_result("gaps", 32'h0376E6E7);
      accept_result("gaps");
   endtask

   task automatic test_masked_lanes();
      send_beat(32'h34333231, 4'b0000, 1'b0);
      send_beat(32'h38373635, 4'b0000, 1'b0);
      send_beat(32'hA5C3F039, 4'b0001, 1'b1);
      check_result("mask_contig", 32'h0376E6E7);
      accept_result("mask_contig");
      send_123456789_noncontig();
      check_result("mask_noncontig", 32'h0376E6E7);
      accept_result("mask_noncontig");
   endtask

   // '9' sits in lane 3 only; the other lanes hold junk that must be ignored
   task automatic send_123456789_noncontig();
      send_beat(32'h34333231, 4'hF, 1'b0);
      send_beat(32'h38373635, 4'hF, 1'b0);
      send_beat(32'h39112233, 4'b1000, 1'b1);
   endtask

   task automatic test_reset_mid_packet();
      send_beat(32'h34333231, 4'hF, 1'b0);
      send_beat(32'h38373635, 4'hF, 1'b0);
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      send_123456789();
      check_result("reset_mid", 32'h0376E6E7);
      accept_result("reset_mid");
   endtask

`ifdef AXIS_CRC_CHECK_EN
   task automatic test_check();
      send_beat(32'h34333231, 4'hF, 1'b0);
      send_beat(32'h38373635, 4'hF, 1'b0);
      send_beat(32'hE6760339, 4'hF, 1'b0);
      send_beat(32'h000000E7, 4'b0001, 1'b1);
      check_result("check_good", 32'h00000000);
      checks++;
      if (crc_ok !== 1'b1) begin
         errors++;
         $display("FAIL check_good_crc_ok: got=%0b required=1", crc_ok);
      end
      accept_result("check_good");
      checks++;
      if (crc_ok !== 1'b0) begin
         errors++;
         $display("FAIL check_clear_crc_ok: got=%0b required=0", crc_ok);
      end
      send_beat(32'h34333231, 4'hF, 1'b0);
      send_beat(32'h38373635, 4'hF, 1'b0);
      send_beat(32'hE6760339, 4'hF, 1'b0);
      send_beat(32'h000000E6, 4'b0001, 1'b1);
      checks++;
      if (crc_ok !== 1'b0 || bus.m_axis_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL check_bad_crc_ok: crc_ok=%0b tvalid=%0b required crc_ok=0 tvalid=1",
                  crc_ok, bus.m_axis_tvalid);
      end
      accept_result("check_bad");
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      aresetn = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tkeep  = '0;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      bus.m_axis_tready = 1'b0;
      test_reset();
      test_basic();
      test_empty();
      test_back_to_back();
      test_gaps();
      test_masked_lanes();
      test_reset_mid_packet();
`ifdef AXIS_CRC_CHECK_EN
      test_check();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
